// File: rtl/genie_split_pkg.sv
// -----------------------------------------------------------------------------
// genie_split_pkg
// Shared types for the genie_split packet broadcast/demux stage.
//   state_t : packet tracking state (waiting for a first beat / inside packet)
// -----------------------------------------------------------------------------
package genie_split_pkg;

    typedef enum logic {
        S_SOP    = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

endpackage : genie_split_pkg

// File: rtl/genie_split.sv
// -----------------------------------------------------------------------------
// genie_split
// Packet-aware broadcast/demux. One valid/ready/eop input stream is fanned out
// to NO output streams according to a destination mask sampled on the first
// beat of each packet and held until eop. Every output handshakes on its own;
// the input beat retires only once all selected outputs have taken it.
// Datapath is purely combinational; only the packet state, the latched mask
// and the per-output "already taken this beat" flags are registered.
//
// Ports
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   i_data   : input beat data (WIDTH bits; one unused bit when WIDTH=0)
//   i_valid  : input beat valid
//   o_ready  : input beat consumed this cycle when high together with i_valid
//   i_eop    : last beat of packet
//   i_mask   : destination mask, sampled on the packet's first beat
//   o_valid  : per-output valid
//   o_data   : i_data replicated into each output slice (zero when WIDTH=0)
//   o_eop    : i_eop replicated to each output
//   i_ready  : per-output ready
// -----------------------------------------------------------------------------
module genie_split
    import genie_split_pkg::*;
#(
    parameter int NO    = 2,
    parameter int WIDTH = 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [((WIDTH > 0) ? WIDTH : 1)-1:0]   i_data,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic                                   i_eop,
    input  logic [NO-1:0]                          i_mask,
    output logic [NO-1:0]                          o_valid,
    output logic [NO*((WIDTH > 0) ? WIDTH : 1)-1:0] o_data,
    output logic [NO-1:0]                          o_eop,
    input  logic [NO-1:0]                          i_ready
);

    localparam int DW = (WIDTH > 0) ? WIDTH : 1;

    state_t          state;
    logic [NO-1:0]   pkt_mask;
    logic [NO-1:0]   done;
    logic [NO-1:0]   eff_mask;
    logic [NO-1:0]   acc;
    logic            beat;

    // The first beat routes on the live mask; later beats ignore i_mask.
    assign eff_mask = (state == S_SOP) ? i_mask : pkt_mask;

    // Unselected outputs and outputs that already took the beat never stall.
    assign o_ready  = &(~eff_mask | done | i_ready);
    assign beat     = i_valid & o_ready;

    for (genvar k = 0; k < NO; k++) begin : g_out
        logic done_q;

        assign o_valid[k] = i_valid & eff_mask[k] & ~done_q;
        assign acc[k]     = o_valid[k] & i_ready[k];
        assign o_eop[k]   = i_eop;
        assign done[k]    = done_q;

        if (WIDTH > 0) begin : g_data
            assign o_data[k*DW +: DW] = i_data;
        end else begin : g_nodata
            assign o_data[k*DW +: DW] = '0;
        end

        // Remember an early accept so the output is not offered the same
        // beat twice while slower outputs catch up.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                done_q <= 1'b0;
            end else if (beat) begin
                done_q <= 1'b0;
            end else if (acc[k]) begin
                done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_SOP;
            pkt_mask <= '0;
        end else begin
            case (state)
                S_SOP: begin
                    if (beat) begin
                        pkt_mask <= eff_mask;
                        if (!i_eop) begin
                            state <= S_IN_PKT;
                        end
                    end
                end
                S_IN_PKT: begin
                    if (beat && i_eop) begin
                        state <= S_SOP;
                    end
                end
                default: state <= S_SOP;
            endcase
        end
    end

    // Upstream must not withdraw a beat that some outputs have already taken.
    a_hold_valid_while_partial : assert property (
        @(posedge clk) disable iff (!reset_n) (|done) |-> i_valid
    );

endmodule : genie_split

// File: tb/tb_genie_split.sv
// -----------------------------------------------------------------------------
// tb_genie_split
// Self-checking bench for genie_split (NO=4, WIDTH=8). Expected beats are
// pushed per output when stimulus is driven and popped when an output
// handshake is observed; directed checks cover ready/valid timing and state.
// -----------------------------------------------------------------------------
module tb_genie_split;
    import genie_split_pkg::*;

    localparam int NO    = 4;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [WIDTH-1:0]   i_data = '0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic               i_eop = 1'b0;
    logic [NO-1:0]      i_mask = '0;
    logic [NO-1:0]      o_valid;
    logic [NO*WIDTH-1:0] o_data;
    logic [NO-1:0]      o_eop;
    logic [NO-1:0]      i_ready = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Per-output scoreboard entries: {eop, data}
    logic [WIDTH:0] sbq [NO][$];

    // Bench model of the packet tracker
    logic           m_in_pkt = 1'b0;
    logic [NO-1:0]  m_mask = '0;

    genie_split #(.NO(NO), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_eop   (i_eop),
        .i_mask  (i_mask),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_eop   (o_eop),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake must match the next expected beat.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < NO; k++) begin
                if (o_valid[k] && i_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        check($sformatf("unexpected_out%0d", k), {o_eop[k], o_data[k*WIDTH +: WIDTH]}, 9'h1ff);
                    end else begin
                        check($sformatf("out%0d_beat", k), {o_eop[k], o_data[k*WIDTH +: WIDTH]}, sbq[k].pop_front());
                    end
                end
            end
        end
    end

    // Present one beat, wait (bounded) for it to retire; report stall cycles and
    // the o_valid seen on the first cycle the beat was offered.
    task automatic send(input logic [WIDTH-1:0] d, input logic e, input logic [NO-1:0] m,
                        output int cyc, output logic [NO-1:0] ov);
        logic [NO-1:0] em;
        em = m_in_pkt ? m_mask : m;
        for (int k = 0; k < NO; k++)
            if (em[k]) sbq[k].push_back({e, d});
        i_data  = d;
        i_eop   = e;
        i_mask  = m;
        i_valid = 1'b1;
        cyc = 0;
        @(negedge clk);
        ov = o_valid;
        while (!o_ready) begin
            cyc++;
            if (cyc > 20) begin
                check("retire_timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!m_in_pkt) m_mask = em;
        m_in_pkt = !e;
        i_valid  = 1'b0;
    endtask

    initial begin
        int            cyc;
        logic [NO-1:0] ov;
        logic [WIDTH-1:0] t1_data [3];
        logic [NO-1:0] t5_mask [3];
        t1_data = '{8'h0A, 8'h0B, 8'h0C};
        t5_mask = '{4'b0001, 4'b0010, 4'b0011};

        // Reset state: outputs follow inputs only
        i_mask = 4'b0101;
        i_ready = 4'b0100;
        #12;
        check("rst_o_valid", o_valid, 4'b0000);
        check("rst_o_ready", o_ready, 1'b0);
        i_ready = 4'b1111;
        #1;
        check("rst_o_ready_all", o_ready, 1'b1);
        check("rst_state", dut.state, S_SOP);
        check("rst_done", dut.done, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. Unicast, all ready
        for (int i = 0; i < 3; i++) begin
            send(t1_data[i], (i == 2), 4'b0100, cyc, ov);
            check($sformatf("t1_stall%0d", i), cyc, 0);
            check($sformatf("t1_valid%0d", i), ov, 4'b0100);
        end
        check("t1_state_end", dut.state, S_SOP);

        // 2. Broadcast with skew
        i_ready = 4'b0001;
        sbq[0].push_back({1'b1, 8'h55});
        sbq[1].push_back({1'b1, 8'h55});
        sbq[3].push_back({1'b1, 8'h55});
        i_data = 8'h55; i_eop = 1'b1; i_mask = 4'b1011; i_valid = 1'b1;
        @(negedge clk);
        check("t2_c0_valid", o_valid, 4'b1011);
        check("t2_c0_ready", o_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_c1_valid", o_valid, 4'b1010);
        check("t2_c1_ready", o_ready, 1'b0);
        check("t2_c1_done", dut.done, 4'b0001);
        @(posedge clk); #1;
        i_ready = 4'b1011;
        @(negedge clk);
        check("t2_c2_valid", o_valid, 4'b1010);
        check("t2_c2_ready", o_ready, 1'b1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("t2_done_clear", dut.done, 4'b0000);
        check("t2_state", dut.state, S_SOP);
        i_ready = 4'b1111;

        // 3. Mask change mid-packet is ignored
        send(8'h31, 1'b0, 4'b0001, cyc, ov);
        check("t3_b0_valid", ov, 4'b0001);
        check("t3_state_in", dut.state, S_IN_PKT);
        send(8'h32, 1'b0, 4'b0010, cyc, ov);
        check("t3_b1_valid", ov, 4'b0001);
        send(8'h33, 1'b1, 4'b0010, cyc, ov);
        check("t3_b2_valid", ov, 4'b0001);
        send(8'h34, 1'b1, 4'b0010, cyc, ov);
        check("t3_next_valid", ov, 4'b0010);

        // 4. Zero mask: consumed and dropped
        send(8'h77, 1'b1, 4'b0000, cyc, ov);
        check("t4_stall", cyc, 0);
        check("t4_valid", ov, 4'b0000);
        check("t4_state", dut.state, S_SOP);

        // 5. Back-to-back single-beat packets
        for (int i = 0; i < 3; i++) begin
            send(8'h50 + 8'(i), 1'b1, t5_mask[i], cyc, ov);
            check($sformatf("t5_valid%0d", i), ov, t5_mask[i]);
            check($sformatf("t5_stall%0d", i), cyc, 0);
            check($sformatf("t5_state%0d", i), dut.state, S_SOP);
        end

        // 6. Reset mid-packet
        send(8'h60, 1'b0, 4'b0011, cyc, ov);
        i_ready = 4'b0001;
        sbq[0].push_back({1'b0, 8'h61});
        i_data = 8'h61; i_eop = 1'b0; i_mask = 4'b0011; i_valid = 1'b1;
        @(posedge clk); #1;
        check("t6_done_pre", dut.done, 4'b0001);
        check("t6_state_pre", dut.state, S_IN_PKT);
        reset_n = 1'b0;
        #1;
        check("t6_state_rst", dut.state, S_SOP);
        check("t6_done_rst", dut.done, 4'b0000);
        i_valid = 1'b0;
        m_in_pkt = 1'b0;
        i_ready = 4'b1111;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(8'h62, 1'b1, 4'b0010, cyc, ov);
        check("t6_fresh_valid", ov, 4'b0010);
        check("t6_state_end", dut.state, S_SOP);

        repeat (2) @(posedge clk);
        for (int k = 0; k < NO; k++)
            check($sformatf("sb_empty%0d", k), sbq[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_genie_split

// File: doc/genie_split.md
Name: genie_split

Overview:
- Packet-aware broadcast/demux stage that consumes one valid/ready/eop stream, for example the output of the round-robin merge, and fans it out to NO output streams.
- Each packet carries a destination mask. The mask is sampled on the first beat and held until eop, so a packet never changes destinations mid-flight.
- Each output handshakes independently. The input beat retires only after every selected output has accepted it.
- Zero-latency combinational datapath with a small amount of tracking state.

Parameters:
- NO, 2, number of output streams (>=1).
- WIDTH, 1, data width per beat. WIDTH=0 removes the data path; valid/eop/mask handling is unchanged.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- i_data  input  WIDTH  input beat data
- i_valid  input  1  input beat valid
- o_ready  output  1  input beat consumed this cycle when high with i_valid
- i_eop  input  1  last beat of packet
- i_mask  input  NO  destination mask; sampled on the packet's first beat
- o_valid  output  NO  per-output valid
- o_data  output  NO*WIDTH  i_data replicated to each output slice
- o_eop  output  NO  i_eop replicated
- i_ready  input  NO  per-output ready

Behaviour:
- Interface decision (fixed): one clock; reset is asynchronous and active-low.
- State registers:
  - state: S_SOP or S_IN_PKT
  - pkt_mask[NO]
  - done[NO]: outputs that have already taken the current beat
- Reset values: state=S_SOP, pkt_mask=0, done=0. Consequently all outputs are driven purely by inputs: o_valid=0 whenever i_valid=0, and o_ready = &(~i_mask | i_ready) while in S_SOP.
- Effective mask: eff_mask = i_mask in S_SOP, pkt_mask in S_IN_PKT.
- Per-output valid: o_valid[k] = i_valid & eff_mask[k] & ~done[k].
- Per-output accept: acc[k] = o_valid[k] & i_ready[k].
- Input ready: o_ready = &(~eff_mask | done | i_ready). It does not depend on i_valid.
- Beat retire: beat = i_valid & o_ready.
- done update: if beat, done <= 0; else done <= done | acc.
- pkt_mask update: loads eff_mask on beat while in S_SOP.
- State transitions:
  - S_SOP -> S_IN_PKT on beat & !i_eop.
  - S_IN_PKT -> S_SOP on beat & i_eop.
  - A single-beat packet (eop on the first beat) stays in S_SOP.
- Latency: 0 cycles from input to output. An output that accepts a beat early sees o_valid low until the slowest selected output accepts, so no duplicate delivery occurs.
- Upstream rule: i_data, i_eop and i_mask must be held stable while i_valid is high and o_ready is low. Mask changes in S_IN_PKT are ignored.
- All-zero eff_mask: the beat is consumed immediately (o_ready=1) and dropped; state transitions still follow eop.
- NO=1: the block degenerates to a pass-through gated by mask bit 0.
- Assertion-level check: i_valid deasserting while done!=0 is an upstream protocol error and must be flagged. The design still clears done only on beat.
- Reset mid-packet: state returns to S_SOP and done clears. The next beat is treated as a new packet's first beat.

Decomposition:
- genie_split_pkg: state enum (S_SOP, S_IN_PKT).
- No sub-module: per-output logic is a one-bit done flag inside a generate loop.
- Reuse is optional, not required.

Test Plan:
1. Unicast, all ready: NO=4, mask=4'b0100, 3-beat packet with data 0xA,0xB,0xC and eop on beat 3 -> only o_valid[2] pulses; o_ready high on all 3 cycles; o_data slice 2 = A,B,C; o_eop[2] on third beat.
2. Broadcast with skew: mask=4'b1011, i_ready=4'b0001 for 2 cycles then 4'b1011 -> output 0 accepts in cycle 0 and its o_valid drops; o_ready stays low until cycle 2; the beat retires once, with no duplicate on output 0.
3. Mask change mid-packet: first beat mask=2'b01, later beats drive i_mask=2'b10 -> all beats go to output 0 only; the next packet after eop goes to output 1.
4. Zero mask: mask=0, single eop beat -> o_ready=1 and o_valid=0 in the same cycle; state stays S_SOP.
5. Back-to-back single-beat packets: masks 01, 10, 11 with all ready -> one beat per cycle to the correct outputs; state never leaves S_SOP.
6. Reset mid-packet: assert reset_n=0 after beat 1 of a 4-beat packet with done=2'b01 -> state=S_SOP and done=0 immediately. After release, the next beat samples i_mask as a fresh first beat.
